// File: rtl/tl_channel_fifo.sv
// Multi-channel FIFO: NUM_CH independent circular buffers sharing one push port
// and one pop port, with registered read data and sticky overflow/underflow flags.
module tl_channel_fifo #(
    parameter int WIDTH        = 12,
    parameter int DEPTH        = 8,
    parameter int NUM_CH       = 4,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [CW-1:0]            push_ch,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    input  logic [CW-1:0]            pop_ch,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        almost_empty,
    output logic [NUM_CH*(AW+1)-1:0] count,
    output logic                     overflow,
    output logic                     underflow
);

    logic [WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [AW-1:0]    wr_ptr [NUM_CH];
    logic [AW-1:0]    rd_ptr [NUM_CH];
    logic [AW:0]      cnt    [NUM_CH];

    logic              pop_ok;
    logic              push_ok;
    logic [NUM_CH-1:0] push_hit;
    logic [NUM_CH-1:0] pop_hit;

    // A full channel still takes a push when the same channel is popped this cycle;
    // an empty channel never pops, so a same-cycle push cannot be read through.
    always_comb begin
        pop_ok  = pop && (cnt[pop_ch] != '0);
        push_ok = push && ((cnt[push_ch] != (AW+1)'(DEPTH)) || (pop_ok && (pop_ch == push_ch)));
        push_hit = '0;
        pop_hit  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            push_hit[i] = push_ok && (push_ch == CW'(i));
            pop_hit[i]  = pop_ok && (pop_ch == CW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok)
            mem[push_ch][wr_ptr[push_ch]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (push_hit[i])
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop_hit[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push_hit[i] && !pop_hit[i])
                    cnt[i] <= cnt[i] + (AW+1)'(1);
                else if (pop_hit[i] && !push_hit[i])
                    cnt[i] <= cnt[i] - (AW+1)'(1);
            end
            valid_out <= pop_ok;
            if (pop_ok)
                data_out <= mem[pop_ch][rd_ptr[pop_ch]];
            // A fresh error outranks a same-cycle clear.
            if (clear_err)
                overflow <= 1'b0;
            if (push && !push_ok)
                overflow <= 1'b1;
            if (clear_err)
                underflow <= 1'b0;
            if (pop && !pop_ok)
                underflow <= 1'b1;
        end
    end

    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        count        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            full[i]         = (cnt[i] == (AW+1)'(DEPTH));
            empty[i]        = (cnt[i] == '0);
            almost_full[i]  = (int'(cnt[i]) >= ALMOST_FULL);
            almost_empty[i] = (int'(cnt[i]) <= ALMOST_EMPTY);
            count[i*(AW+1) +: AW+1] = cnt[i];
        end
    end

endmodule

// File: tb/tb_tl_channel_fifo.sv
// Directed bench for tl_channel_fifo using the default parameter set
// (12-bit data, 8 entries, 4 channels, thresholds 6/1).
module tb_tl_channel_fifo;

    localparam int W  = 12;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic [1:0]    push_ch;
    logic [W-1:0]  data_in;
    logic          pop;
    logic [1:0]    pop_ch;
    logic          clear_err;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic [3:0]    full, empty, almost_full, almost_empty;
    logic [15:0]   count;
    logic          overflow, underflow;

    int vectors    = 0;
    int miscompares = 0;

    tl_channel_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_ch      (push_ch),
        .data_in      (data_in),
        .pop          (pop),
        .pop_ch       (pop_ch),
        .clear_err    (clear_err),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] ch_cnt(input int ch);
        return count[ch*(AW+1) +: AW+1];
    endfunction

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic pu, input logic [1:0] pc, input logic [W-1:0] d,
                         input logic po, input logic [1:0] oc, input logic ce);
        push = pu; push_ch = pc; data_in = d;
        pop = po; pop_ch = oc; clear_err = ce;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(1'b1, 2'd0, 12'h123, 1'b1, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0);
        reset = 1'b1;
        vectors++; if (empty !== 4'hF) begin miscompares++; $display("FAIL reset_empty: got %h want f", empty); end
        vectors++; if (almost_empty !== 4'hF) begin miscompares++; $display("FAIL reset_aempty: got %h want f", almost_empty); end
        vectors++; if (full !== 4'h0) begin miscompares++; $display("FAIL reset_full: got %h want 0", full); end
        vectors++; if (almost_full !== 4'h0) begin miscompares++; $display("FAIL reset_afull: got %h want 0", almost_full); end
        vectors++; if (count !== 16'h0) begin miscompares++; $display("FAIL reset_count: got %h want 0", count); end
        vectors++; if ({valid_out, data_out} !== 13'h0) begin miscompares++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=000", valid_out, data_out); end
        vectors++; if ({overflow, underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b%b want 00", overflow, underflow); end
    endtask

    task automatic test_basic_order();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 2'd2, W'(i), 1'b0, 2'd0, 1'b0);
            vectors++; if (ch_cnt(2) !== (AW+1)'(i)) begin miscompares++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, ch_cnt(2), i); end
            vectors++; if (almost_full[2] !== (i >= 6)) begin miscompares++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full[2], i >= 6); end
        end
        vectors++; if (full !== 4'b0100) begin miscompares++; $display("FAIL full_ch2: got %b want 0100", full); end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd2, 1'b0);
            vectors++; if (valid_out !== 1'b1 || data_out !== W'(i)) begin miscompares++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, W'(i)); end
            vectors++; if (ch_cnt(2) !== (AW+1)'(8 - i)) begin miscompares++; $display("FAIL drain_cnt[%0d]: got %0d want %0d", i, ch_cnt(2), 8 - i); end
        end
        cycle(1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b0);
        vectors++; if (valid_out !== 1'b0 || data_out !== 12'h008) begin miscompares++; $display("FAIL idle_hold: got v=%b d=%h want v=0 d=008", valid_out, data_out); end
        vectors++; if (empty[2] !== 1'b1 || underflow !== 1'b0) begin miscompares++; $display("FAIL drained_state: got e=%b u=%b want e=1 u=0", empty[2], underflow); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 2'd0, W'(12'h100 + i), 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 12'h777, 1'b0, 2'd0, 1'b0);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
        vectors++; if (ch_cnt(0) !== 4'd8) begin miscompares++; $display("FAIL ovf_cnt: got %0d want 8", ch_cnt(0)); end
        cycle(1'b1, 2'd0, 12'h778, 1'b0, 2'd0, 1'b1);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_clear_vs_new: got %b want 1", overflow); end
        cycle(1'b0, 2'd0, 12'h000, 1'b0, 2'd0, 1'b1);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd0, 1'b0);
            vectors++; if (valid_out !== 1'b1 || data_out !== W'(12'h100 + i)) begin miscompares++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, W'(12'h100 + i)); end
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 2'd1, W'(12'h200 + i), 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 12'hABC, 1'b1, 2'd1, 1'b0);
        vectors++; if (valid_out !== 1'b1 || data_out !== 12'h200) begin miscompares++; $display("FAIL fpp_data: got v=%b d=%h want v=1 d=200", valid_out, data_out); end
        vectors++; if (ch_cnt(1) !== 4'd8 || overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_state: got cnt=%0d ovf=%b want cnt=8 ovf=0", ch_cnt(1), overflow); end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd1, 1'b0);
            vectors++; if (data_out !== ((i == 8) ? 12'hABC : W'(12'h200 + i))) begin miscompares++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, data_out, (i == 8) ? 12'hABC : W'(12'h200 + i)); end
        end
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b1, 2'd3, 12'h055, 1'b1, 2'd3, 1'b0);
        vectors++; if (underflow !== 1'b1 || valid_out !== 1'b0) begin miscompares++; $display("FAIL epp_flags: got u=%b v=%b want u=1 v=0", underflow, valid_out); end
        vectors++; if (ch_cnt(3) !== 4'd1 || data_out !== 12'hABC) begin miscompares++; $display("FAIL epp_state: got cnt=%0d d=%h want cnt=1 d=abc", ch_cnt(3), data_out); end
        cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd3, 1'b1);
        vectors++; if (underflow !== 1'b0 || data_out !== 12'h055) begin miscompares++; $display("FAIL epp_pop: got u=%b d=%h want u=0 d=055", underflow, data_out); end
    endtask

    task automatic test_cross_channel();
        cycle(1'b1, 2'd2, 12'h0AA, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd0, 12'h0BB, 1'b1, 2'd2, 1'b0);
        vectors++; if (data_out !== 12'h0AA || ch_cnt(0) !== 4'd1 || ch_cnt(2) !== 4'd0) begin miscompares++; $display("FAIL xch: got d=%h c0=%0d c2=%0d want d=0aa c0=1 c2=0", data_out, ch_cnt(0), ch_cnt(2)); end
        cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd0, 1'b0);
        vectors++; if (data_out !== 12'h0BB || valid_out !== 1'b1) begin miscompares++; $display("FAIL xch_pop: got v=%b d=%h want v=1 d=0bb", valid_out, data_out); end
    endtask

    // ch0 pointers start at 1 here, so 12 pushes wrap the buffer.
    task automatic test_back_to_back_wrap();
        int out_idx = 0;
        logic [W-1:0] exp;
        for (int k = 0; k < 14; k++) begin
            cycle(k < 12, 2'd0, W'(12'h300 + k * 12'h011), k >= 2, 2'd0, 1'b0);
            if (k >= 2) begin
                exp = W'(12'h300 + out_idx * 12'h011);
                vectors++; if (valid_out !== 1'b1 || data_out !== exp) begin miscompares++; $display("FAIL wrap[%0d]: got v=%b d=%h want v=1 d=%h", out_idx, valid_out, data_out, exp); end
                out_idx++;
            end
        end
        vectors++; if (empty[0] !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL wrap_end: got e=%b u=%b o=%b want 1 0 0", empty[0], underflow, overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 2'd1, W'(12'h400 + i), 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd3, 1'b0);
        vectors++; if (underflow !== 1'b1 || ch_cnt(1) !== 4'd5) begin miscompares++; $display("FAIL pre_reset: got u=%b c1=%0d want u=1 c1=5", underflow, ch_cnt(1)); end
        reset = 1'b0;
        cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd1, 1'b0);
        reset = 1'b1;
        vectors++; if (ch_cnt(1) !== 4'd0 || empty[1] !== 1'b1) begin miscompares++; $display("FAIL mid_reset_cnt: got c1=%0d e=%b want 0 1", ch_cnt(1), empty[1]); end
        vectors++; if (valid_out !== 1'b0 || data_out !== 12'h000 || underflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset_out: got v=%b d=%h u=%b want 0 000 0", valid_out, data_out, underflow); end
        cycle(1'b0, 2'd0, 12'h000, 1'b1, 2'd1, 1'b0);
        vectors++; if (valid_out !== 1'b0 || underflow !== 1'b1) begin miscompares++; $display("FAIL post_reset_pop: got v=%b u=%b want 0 1", valid_out, underflow); end
    endtask

    initial begin
        push = 1'b0; push_ch = '0; data_in = '0;
        pop = 1'b0; pop_ch = '0; clear_err = 1'b0; reset = 1'b0;
        test_reset();
        test_basic_order();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_cross_channel();
        test_back_to_back_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_channel_fifo.md
TL_CHANNEL_FIFO -- requirements
Module: tl_channel_fifo

Interface
REQ-001 Parameter WIDTH, default 12, data word width in bits.
REQ-002 Parameter DEPTH, default 8, entries per channel; SHALL be a power of two, at least 2.
REQ-003 Parameter NUM_CH, default 4, independent channels; SHALL be a power of two, at least 2.
REQ-004 Parameter ALMOST_FULL, default 6, almost-full threshold, applied per channel.
REQ-005 Parameter ALMOST_EMPTY, default 1, almost-empty threshold, applied per channel.
REQ-006 Derived widths: AW = log2(DEPTH), CW = log2(NUM_CH).
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 reset  input  1  reset, synchronous, active-low.
REQ-009 push  input  1  write request.
REQ-010 push_ch  input  CW  target channel of push.
REQ-011 data_in  input  WIDTH  write data.
REQ-012 pop  input  1  read request.
REQ-013 pop_ch  input  CW  source channel of pop.
REQ-014 clear_err  input  1  clears the sticky error flags.
REQ-015 data_out  output  WIDTH  registered read data.
REQ-016 valid_out  output  1  data_out holds data from a pop accepted in the previous cycle.
REQ-017 full, empty, almost_full, almost_empty  output  NUM_CH each  per-channel status; bit i refers to channel i.
REQ-018 count  output  NUM_CH*(AW+1)  per-channel occupancy; channel i occupies bits [i*(AW+1) +: AW+1].
REQ-019 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-020 Each channel SHALL be a circular buffer of DEPTH x WIDTH with its own write pointer, read pointer and count; storage is internal.
REQ-021 A push SHALL be accepted when push=1 and channel push_ch is not full.
 - On acceptance: data_in is written at that channel's write pointer; the write pointer increments modulo DEPTH.
REQ-022 A pop SHALL be accepted when pop=1 and channel pop_ch is not empty.
 - On acceptance: the entry at that channel's read pointer is registered into data_out at the next edge; the read pointer increments modulo DEPTH; valid_out=1 for exactly that cycle.
 - Pop-to-data latency is one cycle.
REQ-023 When no pop is accepted, valid_out SHALL be 0 and data_out SHALL hold its previous value.
REQ-024 Count update per channel: +1 on accepted push only, -1 on accepted pop only, unchanged when both or neither are accepted; count never leaves the range 0..DEPTH.
REQ-025 Push and pop on the same channel in the same cycle: both SHALL be accepted when the channel is non-empty, including when it is full.
 - Push to a full channel with a same-cycle accepted pop on that channel SHALL be accepted.
REQ-026 Push and pop on an empty channel in the same cycle: the push SHALL be accepted and the pop rejected; no read-through.
REQ-027 Push and pop on different channels SHALL be evaluated fully independently.
REQ-028 A rejected push (channel full, no same-cycle pop on it) SHALL be dropped, leave state unchanged, and set overflow at the next edge.
REQ-029 A rejected pop (channel empty) SHALL be dropped, leave state unchanged, keep valid_out=0, and set underflow at the next edge.
REQ-030 overflow and underflow SHALL stay set until clear_err=1 or reset; a new error in the same cycle as clear_err SHALL leave the flag set.
REQ-031 Status flags SHALL be combinational from the registered counts:
 - full = (count == DEPTH)
 - empty = (count == 0)
 - almost_full = (count >= ALMOST_FULL)
 - almost_empty = (count <= ALMOST_EMPTY)
 - almost_full and almost_empty are independent and MAY both be 1.
REQ-032 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering; each channel is strictly FIFO-ordered.

Reset
REQ-033 While reset=0 at a clock edge, the block SHALL set all pointers and counts to 0, data_out to 0, valid_out to 0, and overflow/underflow to 0; push and pop are ignored.
REQ-034 After reset: empty and almost_empty are all 1; full and almost_full are all 0.
REQ-035 Storage contents are not reset.
REQ-036 Reset asserted mid-operation SHALL discard all channel contents; no pop-data is delivered after the reset edge.

Verification
REQ-037 Reset, then push 0x001..0x008 into ch2 and pop ch2 eight times -> data_out 0x001..0x008 in order, valid_out one cycle after each pop; ch2 count path 8 -> 0; full[2]=1 at count 8.
REQ-038 Ch0 full (8 entries), push ch0 -> overflow=1, count stays 8; assert clear_err -> overflow=0.
REQ-039 Ch1 full, push 0xABC and pop ch1 in the same cycle -> count stays 8; 0xABC is read out as the eighth subsequent pop.
REQ-040 Ch3 empty, push 0x055 and pop ch3 in the same cycle -> underflow=1, valid_out=0, count[3]=1.
REQ-041 Push 12 words and pop 12 words on ch0 interleaved, crossing the pointer wrap -> all 12 values returned in order with no loss.
REQ-042 Fill ch1 with 5 entries, assert reset=0 for one cycle -> count=0, empty[1]=1, valid_out=0, errors cleared.
